// File: rtl/median_frame_ctrl.sv
// rtl/median_frame_ctrl.sv - frame sequencer feeding a 3x3 median filter from a column-major source memory
// Optional feature: define MEDIAN_CTRL_BYPASS_EN to add the bypass input (window centre written straight out).
module median_frame_ctrl #(
    parameter int ROW    = 554,
    parameter int COL    = 430,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [31:0]       flt_pixel,
    output logic [71:0]       flt_win,
    input  logic [7:0]        flt_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
`ifdef MEDIAN_CTRL_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              wr_ready
);

    localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(ROW);
    localparam logic [ADDR_W-1:0] ROW_M1 = ADDR_W'(ROW - 1);
    localparam logic [ADDR_W-1:0] COL_M1 = ADDR_W'(COL - 1);
    localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(ROW * COL - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [31:0]       P_END  = 32'(ROW * COL);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, FILT, CAPT, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [ADDR_W-1:0] r_q, r_d, c_q, c_d, p_q, p_d;
    logic [ADDR_W-1:0] r_nx, c_nx, p_nx;
    logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
    logic              wr_valid_q, wr_valid_d, bypass_q, bypass_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [31:0]       flt_pixel_q, flt_pixel_d;
    logic [71:0]       win_q, win_d;
    logic [7:0]        wr_data_q, wr_data_d;

    // Clamped neighbours collapse their offset to zero, so addresses come from p with adders only.
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] p,
                                                   input logic [ADDR_W-1:0] r,
                                                   input logic [ADDR_W-1:0] c,
                                                   input logic [3:0]        k);
        logic [ADDR_W-1:0] a;
        a = p;
        if (k <= 4'd2 && r != '0) a = a - ONE;
        if (k >= 4'd6 && r != ROW_M1) a = a + ONE;
        if ((k == 4'd0 || k == 4'd3 || k == 4'd6) && c != '0) a = a - ROW_A;
        if ((k == 4'd2 || k == 4'd5 || k == 4'd8) && c != COL_M1) a = a + ROW_A;
        return a;
    endfunction

    assign r_nx = (r_q == ROW_M1) ? '0 : r_q + ONE;
    assign c_nx = (r_q == ROW_M1) ? c_q + ONE : c_q;
    assign p_nx = p_q + ONE;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        r_d         = r_q;
        c_d         = c_q;
        p_d         = p_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        flt_pixel_d = flt_pixel_q;
        win_d       = win_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bypass_d    = bypass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    r_d       = '0;
                    c_d       = '0;
                    p_d       = '0;
                    k_d       = 4'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = tap_addr('0, '0, '0, 4'd0);
`ifdef MEDIAN_CTRL_BYPASS_EN
                    bypass_d  = bypass;
`else
                    bypass_d  = 1'b0;
`endif
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                // Read data lags the strobe by one cycle, so cycle k lands tap k-1.
                for (int i = 0; i < 8; i++) begin
                    if (k_q == 4'(i + 1)) win_d[8*i +: 8] = rd_data;
                end
                if (k_q == 4'd8) begin
                    rd_en_d = 1'b0;
                    state_d = LAST;
                end else begin
                    k_d       = k_q + 4'd1;
                    rd_addr_d = tap_addr(p_q, r_q, c_q, k_q + 4'd1);
                end
            end
            LAST: begin
                win_d[71:64] = rd_data;
                if (bypass_q) begin
                    wr_data_d  = win_q[39:32];
                    wr_valid_d = 1'b1;
                    wr_addr_d  = p_q;
                    state_d    = WRITE;
                end else begin
                    flt_pixel_d = 32'(p_q);
                    state_d     = FILT;
                end
            end
            FILT: state_d = CAPT;
            CAPT: begin
                wr_data_d  = flt_data;
                wr_valid_d = 1'b1;
                wr_addr_d  = p_q;
                state_d    = WRITE;
            end
            WRITE: begin
                if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (p_q == P_LAST) begin
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        flt_pixel_d = P_END;
                        state_d     = DONE;
                    end else begin
                        r_d       = r_nx;
                        c_d       = c_nx;
                        p_d       = p_nx;
                        k_d       = 4'd0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = tap_addr(p_nx, r_nx, c_nx, 4'd0);
                        state_d   = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            p_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            flt_pixel_q <= '0;
            win_q       <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            bypass_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            r_q         <= r_d;
            c_q         <= c_d;
            p_q         <= p_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            flt_pixel_q <= flt_pixel_d;
            win_q       <= win_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            bypass_q    <= bypass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign flt_pixel = flt_pixel_q;
    assign flt_win   = win_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb/tb_median_frame_ctrl.sv - directed bench for median_frame_ctrl on a 4x3 frame
module tb_median_frame_ctrl;
    localparam int ROW  = 4;
    localparam int COL  = 3;
    localparam int AW   = 8;
    localparam int NPIX = ROW * COL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          wr_ready = 1'b1;
    logic          busy, done, rd_en, wr_valid;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0]    rd_data = '0;
    logic [7:0]    flt_data = '0;
    logic [7:0]    wr_data;
    logic [31:0]   flt_pixel;
    logic [71:0]   flt_win;
`ifdef MEDIAN_CTRL_BYPASS_EN
    logic          bypass = 1'b0;
`endif

    logic [7:0]    mem [256];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [AW-1:0] wa [$];
    logic [7:0]    wd [$];
    int            wc [$];
    logic [AW-1:0] ra [$];
    int            ndone = 0;
    int            done_cyc = 0;
    int            exp_a0 [9] = '{0, 0, 4, 0, 0, 4, 1, 1, 5};
    int            exp_a5 [9] = '{0, 4, 8, 1, 5, 9, 2, 6, 10};

    median_frame_ctrl #(.ROW(ROW), .COL(COL), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .flt_pixel(flt_pixel), .flt_win(flt_win), .flt_data(flt_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MEDIAN_CTRL_BYPASS_EN
        .bypass(bypass),
`endif
        .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] v [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) v[i] = w[8*i +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return v[4];
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        flt_data <= median9(flt_win);
    end

    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
        if (rd_en) ra.push_back(rd_addr);
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); ra.delete();
        ndone = 0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 10);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (ndone == 0 && i < budget) begin @(posedge clk); #1; i++; end
        check_val("done_seen", 72'(ndone != 0), 72'd1);
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (wr_valid !== 1'b1 && i < 50) begin @(posedge clk); #1; i++; end
        check_val("wr_valid_seen", 72'(wr_valid), 72'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, 72'(busy), 72'd0);
        check_val({tag, "_done"}, 72'(done), 72'd0);
        check_val({tag, "_rd_en"}, 72'(rd_en), 72'd0);
        check_val({tag, "_wr_valid"}, 72'(wr_valid), 72'd0);
        check_val({tag, "_rd_addr"}, 72'(rd_addr), 72'd0);
        check_val({tag, "_wr_addr"}, 72'(wr_addr), 72'd0);
        check_val({tag, "_wr_data"}, 72'(wr_data), 72'd0);
        check_val({tag, "_flt_pixel"}, 72'(flt_pixel), 72'd0);
        check_val({tag, "_flt_win"}, flt_win, 72'd0);
    endtask

    initial begin
        logic [7:0] hold_d;
        int         n_rd;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst_n = 1'b1;

        // Ramp frame: ordering, spacing, done timing and tap addresses.
        fill_ramp();
        clear_log();
        pulse_start();
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        check_val("busy_after", 72'(busy), 72'd0);
        check_val("done_count", 72'(ndone), 72'd1);
        check_val("flt_pixel_end", 72'(flt_pixel), 72'(NPIX));
        check_val("write_count", 72'(wa.size()), 72'(NPIX));
        for (int i = 0; i < wa.size(); i++) check_val("write_addr", 72'(wa[i]), 72'(i));
        for (int i = 1; i < wc.size(); i++) check_val("write_gap", 72'(wc[i] - wc[i-1]), 72'd13);
        if (wc.size() == NPIX) check_val("done_after_last", 72'(done_cyc), 72'(wc[NPIX-1] + 1));
        check_val("read_count", 72'(ra.size()), 72'(NPIX * 9));
        if (ra.size() >= 54) begin
            for (int k = 0; k < 9; k++) check_val("tap_p0", 72'(ra[k]), 72'(exp_a0[k]));
            for (int k = 0; k < 9; k++) check_val("tap_p5", 72'(ra[45 + k]), 72'(exp_a5[k]));
        end
        if (wd.size() > 5) check_val("data_p5", 72'(wd[5]), 72'd50);

        // Flat frame with a single impulse: the median removes it everywhere.
        for (int i = 0; i < 256; i++) mem[i] = 8'h7F;
        mem[5] = 8'hFF;
        clear_log();
        pulse_start();
        wait_done(400);
        check_val("impulse_count", 72'(wd.size()), 72'(NPIX));
        for (int i = 0; i < wd.size(); i++) check_val("impulse_data", 72'(wd[i]), 72'h7F);

        // Back-pressure at p=2.
        fill_ramp();
        clear_log();
        wr_ready = 1'b0;
        pulse_start();
        for (int n = 0; n < 2; n++) begin
            wait_valid();
            wr_ready = 1'b1;
            @(posedge clk); #1 wr_ready = 1'b0;
        end
        wait_valid();
        check_val("stall_addr0", 72'(wr_addr), 72'd2);
        hold_d = wr_data;
        n_rd = ra.size();
        repeat (5) begin
            @(posedge clk); #1;
            check_val("stall_valid", 72'(wr_valid), 72'd1);
            check_val("stall_addr", 72'(wr_addr), 72'd2);
            check_val("stall_data", 72'(wr_data), 72'(hold_d));
        end
        check_val("stall_no_reads", 72'(ra.size()), 72'(n_rd));
        wr_ready = 1'b1;
        wait_done(400);
        check_val("stall_writes", 72'(wa.size()), 72'(NPIX));
        if (wa.size() > 3) check_val("stall_resume_addr", 72'(wa[3]), 72'd3);

        // Reset in the middle of fetching p=7, then restart.
        clear_log();
        pulse_start();
        begin
            int i;
            i = 0;
            while (ra.size() < 66 && i < 300) begin @(posedge clk); #1; i++; end
            check_val("reached_p7", 72'(ra.size() >= 66), 72'd1);
        end
        check_val("midframe_busy", 72'(busy), 72'd1);
        rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_val("no_done_after_reset", 72'(ndone), 72'd0);
        check_val("idle_after_reset", 72'(busy), 72'd0);
        clear_log();
        pulse_start();
        wait_done(400);
        check_val("restart_writes", 72'(wa.size()), 72'(NPIX));
        if (wa.size() > 0) check_val("restart_first_addr", 72'(wa[0]), 72'd0);

`ifdef MEDIAN_CTRL_BYPASS_EN
        // Bypass: the centre tap goes straight out, 11 cycles per pixel.
        bypass = 1'b1;
        fill_ramp();
        clear_log();
        pulse_start();
        bypass = 1'b0;
        wait_done(400);
        check_val("bypass_count", 72'(wd.size()), 72'(NPIX));
        for (int i = 0; i < wd.size(); i++) check_val("bypass_data", 72'(wd[i]), 72'(8'(i * 10)));
        for (int i = 1; i < wc.size(); i++) check_val("bypass_gap", 72'(wc[i] - wc[i-1]), 72'd11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
